// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 timing defaults, coordinate type and sync decode used by
// vga_timing_gen and by the display blocks that consume x/y.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned H_DISPLAY_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned H_TOTAL_DEF   = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  localparam int unsigned V_DISPLAY_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;
  localparam int unsigned V_TOTAL_DEF   = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int unsigned HSYNC_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int unsigned HSYNC_END_DEF   = HSYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int unsigned VSYNC_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int unsigned VSYNC_END_DEF   = VSYNC_START_DEF + V_SYNC_DEF - 1;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;

  localparam sync_t SYNC_RESET = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b1};

  // Syncs are active-low inside their inclusive [start, end] windows.
  function automatic sync_t decode_sync(
    input coord_t xc,
    input coord_t yc,
    input coord_t h_disp,
    input coord_t hs_start,
    input coord_t hs_end,
    input coord_t v_disp,
    input coord_t vs_start,
    input coord_t vs_end
  );
    sync_t s;
    s.hsync    = !((xc >= hs_start) && (xc <= hs_end));
    s.vsync    = !((yc >= vs_start) && (yc <= vs_end));
    s.video_on = (xc < h_disp) && (yc < v_disp);
    return s;
  endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick.sv
// Pixel-rate strobe: divides clk by CLK_DIV into a registered one-clk p_tick.
module vga_pixel_tick
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic p_tick
);

  localparam int unsigned           DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             p_tick_q, p_tick_d;

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    p_tick_d  = (div_cnt_q == DIV_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      p_tick_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      p_tick_q  <= p_tick_d;
    end
  end

  assign p_tick = p_tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA scan counters, sync decode and frame_start pulse driven by vga_pixel_tick.
// Optional VGA_TIMING_GEN_SYNC_DELAY_EN adds one pixel-tick stage to hsync/vsync/video_on.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               p_tick,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_DISP_C = coord_t'(H_DISPLAY);
  localparam coord_t V_DISP_C = coord_t'(V_DISPLAY);
  localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic   tick;
  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   frame_start_q, frame_start_d;
  sync_t  sync_q, sync_d;
  sync_t  sync_out;

  vga_pixel_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .p_tick  (tick)
  );

  // Decoding from the next-state counters keeps the registered syncs aligned with x/y.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    if (tick) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + coord_t'(1);
        end
      end else begin
        x_d = x_q + coord_t'(1);
      end
    end
    sync_d = decode_sync(x_d, y_d, H_DISP_C, HS_START, HS_END, V_DISP_C, VS_START, VS_END);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      sync_q        <= SYNC_RESET;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      sync_q        <= sync_d;
    end
  end

`ifdef VGA_TIMING_GEN_SYNC_DELAY_EN
  sync_t sync_dly_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_dly_q <= SYNC_RESET;
    end else if (tick) begin
      sync_dly_q <= sync_q;
    end
  end

  assign sync_out = sync_dly_q;
`else
  assign sync_out = sync_q;
`endif

  assign p_tick      = tick;
  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = sync_out.hsync;
  assign vsync       = sync_out.vsync;
  assign video_on    = sync_out.video_on;
  assign frame_start = frame_start_q;

endmodule
